// File: rtl/cpu_clock_switch_ctrl.sv
// CPU clock mux sequencer: debounced stock/turbo switch plus one-hot turbo source select,
// changed only on an idle bus with guard time on C7M. Optional bus-wait timeout: CLKSW_BUS_TIMEOUT_EN.
module cpu_clock_switch_ctrl #(
  parameter int unsigned NUM_CLK       = 8,
  parameter int unsigned SEL_W         = 3,
  parameter int unsigned DEBOUNCE_BITS = 16,
  parameter int unsigned GUARD_CYCLES  = 4
) (
  input  logic               C7M,
  input  logic               RESET_n,
  input  logic               SW1,
  input  logic [SEL_W-1:0]   CLKSEL_REQ,
  input  logic               AS_CPU_n,
  output logic [NUM_CLK-1:0] clksel_onehot,
  output logic               use_stock,
  output logic               busy,
  output logic [SEL_W-1:0]   cur_sel
`ifdef CLKSW_BUS_TIMEOUT_EN
  ,
  output logic               timeout_flag
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN_A,
    ST_GUARD_PRE,
    ST_GUARD_POST,
    ST_DRAIN_B
  } state_t;

  localparam logic [DEBOUNCE_BITS-1:0] DB_LAST  = {{(DEBOUNCE_BITS-1){1'b1}}, 1'b0};
  localparam logic [7:0]               GUARD_LD = 8'(GUARD_CYCLES);
  localparam logic [NUM_CLK-1:0]       ONEHOT_0 = {{(NUM_CLK-1){1'b0}}, 1'b1};

  logic                     sw1_s1_q, sw1_s2_q, as_s1_q, as_s2_q;
  logic [SEL_W-1:0]         sel_s1_q, sel_s2_q;
  logic                     sw1_deb_q, sw1_deb_d;
  logic [SEL_W-1:0]         sel_deb_q, sel_deb_d;
  logic [DEBOUNCE_BITS-1:0] sw1_cnt_q, sw1_cnt_d, sel_cnt_q, sel_cnt_d;
  state_t                   state_q, state_d;
  logic [7:0]               gcnt_q, gcnt_d;
  logic [SEL_W-1:0]         target_q, target_d, cur_sel_q, cur_sel_d;
  logic [NUM_CLK-1:0]       onehot_q, onehot_d;
  logic                     use_stock_q, use_stock_d;
  logic                     bus_idle, drain_go, sel_valid;

  assign bus_idle  = as_s2_q;
  assign sel_valid = 32'(sel_deb_q) < NUM_CLK;

`ifdef CLKSW_BUS_TIMEOUT_EN
  logic [11:0] to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;

  // A stuck bus in a drain state is treated as idle once the wait counter saturates.
  assign drain_go     = bus_idle || (to_cnt_q == 12'hFFF);
  assign timeout_flag = timeout_q;

  always_comb begin
    to_cnt_d  = '0;
    timeout_d = timeout_q;
    if ((state_q == ST_DRAIN_A || state_q == ST_DRAIN_B) && !bus_idle) begin
      if (to_cnt_q == 12'hFFF) timeout_d = 1'b1;
      else                     to_cnt_d  = to_cnt_q + 12'd1;
    end
  end

  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
`else
  assign drain_go = bus_idle;
`endif

  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      sw1_s1_q <= 1'b1;
      sw1_s2_q <= 1'b1;
      sel_s1_q <= '0;
      sel_s2_q <= '0;
      as_s1_q  <= 1'b1;
      as_s2_q  <= 1'b1;
    end else begin
      sw1_s1_q <= SW1;
      sw1_s2_q <= sw1_s1_q;
      sel_s1_q <= CLKSEL_REQ;
      sel_s2_q <= sel_s1_q;
      as_s1_q  <= AS_CPU_n;
      as_s2_q  <= as_s1_q;
    end
  end

  // The first-stage sample counts as the newer sample: a mismatch there restarts the count.
  always_comb begin
    sw1_deb_d = sw1_deb_q;
    sw1_cnt_d = '0;
    if (sw1_s2_q != sw1_deb_q && sw1_s1_q == sw1_s2_q) begin
      if (sw1_cnt_q == DB_LAST) sw1_deb_d = sw1_s2_q;
      else                      sw1_cnt_d = sw1_cnt_q + DEBOUNCE_BITS'(1);
    end
    sel_deb_d = sel_deb_q;
    sel_cnt_d = '0;
    if (sel_s2_q != sel_deb_q && sel_s1_q == sel_s2_q) begin
      if (sel_cnt_q == DB_LAST) sel_deb_d = sel_s2_q;
      else                      sel_cnt_d = sel_cnt_q + DEBOUNCE_BITS'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    gcnt_d      = gcnt_q;
    target_d    = target_q;
    cur_sel_d   = cur_sel_q;
    onehot_d    = onehot_q;
    use_stock_d = use_stock_q;
    case (state_q)
      ST_IDLE: begin
        if (sel_valid && sel_deb_q != cur_sel_q) begin
          target_d = sel_deb_q;
          state_d  = ST_DRAIN_A;
        end else if (sw1_deb_q != use_stock_q && bus_idle) begin
          use_stock_d = sw1_deb_q;
        end
      end
      ST_DRAIN_A: begin
        if (drain_go) begin
          use_stock_d = 1'b1;
          gcnt_d      = GUARD_LD;
          state_d     = ST_GUARD_PRE;
        end
      end
      ST_GUARD_PRE: begin
        if (gcnt_q <= 8'd1) begin
          onehot_d  = ONEHOT_0 << target_q;
          cur_sel_d = target_q;
          gcnt_d    = GUARD_LD;
          state_d   = ST_GUARD_POST;
        end else begin
          gcnt_d = gcnt_q - 8'd1;
        end
      end
      ST_GUARD_POST: begin
        if (gcnt_q <= 8'd1) state_d = ST_DRAIN_B;
        else                gcnt_d  = gcnt_q - 8'd1;
      end
      ST_DRAIN_B: begin
        if (drain_go) begin
          use_stock_d = sw1_deb_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge C7M or negedge RESET_n) begin
    if (!RESET_n) begin
      sw1_deb_q   <= 1'b1;
      sw1_cnt_q   <= '0;
      sel_deb_q   <= '0;
      sel_cnt_q   <= '0;
      state_q     <= ST_IDLE;
      gcnt_q      <= '0;
      target_q    <= '0;
      cur_sel_q   <= '0;
      onehot_q    <= ONEHOT_0;
      use_stock_q <= 1'b1;
    end else begin
      sw1_deb_q   <= sw1_deb_d;
      sw1_cnt_q   <= sw1_cnt_d;
      sel_deb_q   <= sel_deb_d;
      sel_cnt_q   <= sel_cnt_d;
      state_q     <= state_d;
      gcnt_q      <= gcnt_d;
      target_q    <= target_d;
      cur_sel_q   <= cur_sel_d;
      onehot_q    <= onehot_d;
      use_stock_q <= use_stock_d;
    end
  end

  assign clksel_onehot = onehot_q;
  assign use_stock     = use_stock_q;
  assign cur_sel       = cur_sel_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_clock_switch_ctrl.sv
// Self-checking bench for cpu_clock_switch_ctrl: directed steps plus random traffic
// against a stable-window / deadline reference model.
module tb_cpu_clock_switch_ctrl;

  localparam int NUM_CLK = 8;
  localparam int SEL_W   = 3;
  localparam int DB_BITS = 3;
  localparam int GUARD   = 4;
  localparam int WINDOW  = 8;  // samples that must agree before the debounced value moves
  localparam int P_IDLE = 0, P_DRAIN_A = 1, P_PRE = 2, P_POST = 3, P_DRAIN_B = 4;
  localparam logic [NUM_CLK-1:0] ONE = 8'h01;

  logic               C7M = 1'b0;
  logic               RESET_n;
  logic               SW1;
  logic [SEL_W-1:0]   CLKSEL_REQ;
  logic               AS_CPU_n;
  logic [NUM_CLK-1:0] clksel_onehot;
  logic               use_stock;
  logic               busy;
  logic [SEL_W-1:0]   cur_sel;
`ifdef CLKSW_BUS_TIMEOUT_EN
  logic               timeout_flag;
`endif

  int checks = 0;
  int errors = 0;

  always #5 C7M = ~C7M;

  cpu_clock_switch_ctrl #(
    .NUM_CLK      (NUM_CLK),
    .SEL_W        (SEL_W),
    .DEBOUNCE_BITS(DB_BITS),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .C7M          (C7M),
    .RESET_n      (RESET_n),
    .SW1          (SW1),
    .CLKSEL_REQ   (CLKSEL_REQ),
    .AS_CPU_n     (AS_CPU_n),
    .clksel_onehot(clksel_onehot),
    .use_stock    (use_stock),
    .busy         (busy),
    .cur_sel      (cur_sel)
`ifdef CLKSW_BUS_TIMEOUT_EN
    ,
    .timeout_flag (timeout_flag)
`endif
  );

  // Reference model: raw input history, phase, and absolute-time deadlines for the guards.
  logic             m_sw_hist[$];
  logic [SEL_W-1:0] m_sel_hist[$];
  logic             m_as_hist[$];
  logic             m_sw_deb, m_use_stock, m_tflag;
  logic [SEL_W-1:0] m_sel_deb, m_cur, m_target;
  int               m_phase, m_cyc, m_deadline;
`ifdef CLKSW_BUS_TIMEOUT_EN
  int               m_wait;
`endif

  task automatic model_reset();
    m_sw_hist.delete();
    m_sel_hist.delete();
    m_as_hist.delete();
    for (int i = 0; i < WINDOW; i++) begin
      m_sw_hist.push_back(1'b1);
      m_sel_hist.push_back('0);
      m_as_hist.push_back(1'b1);
    end
    m_sw_deb = 1'b1; m_sel_deb = '0; m_use_stock = 1'b1; m_cur = '0; m_target = '0;
    m_phase = P_IDLE; m_cyc = 0; m_deadline = 0; m_tflag = 1'b0;
`ifdef CLKSW_BUS_TIMEOUT_EN
    m_wait = 0;
`endif
  endtask

  task automatic model_step();
    logic idle, go, sw_same, sel_same;
    m_cyc++;
    idle = m_as_hist[m_as_hist.size()-2];  // bus state seen through two sync stages
    go   = idle;
`ifdef CLKSW_BUS_TIMEOUT_EN
    if ((m_phase == P_DRAIN_A || m_phase == P_DRAIN_B) && !idle) begin
      m_wait++;
      if (m_wait >= 4096) begin go = 1'b1; m_tflag = 1'b1; end
    end
`endif
    case (m_phase)
      P_IDLE:
        if (m_sel_deb < NUM_CLK && m_sel_deb != m_cur) begin
          m_target = m_sel_deb; m_phase = P_DRAIN_A;
        end else if (idle && m_sw_deb != m_use_stock) begin
          m_use_stock = m_sw_deb;
        end
      P_DRAIN_A:
        if (go) begin m_use_stock = 1'b1; m_deadline = m_cyc + GUARD; m_phase = P_PRE; end
      P_PRE:
        if (m_cyc == m_deadline) begin m_cur = m_target; m_deadline = m_cyc + GUARD; m_phase = P_POST; end
      P_POST:
        if (m_cyc == m_deadline) m_phase = P_DRAIN_B;
      P_DRAIN_B:
        if (go) begin m_use_stock = m_sw_deb; m_phase = P_IDLE; end
      default: ;
    endcase
`ifdef CLKSW_BUS_TIMEOUT_EN
    if (m_phase != P_DRAIN_A && m_phase != P_DRAIN_B) m_wait = 0;
`endif
    sw_same = 1'b1; sel_same = 1'b1;
    for (int i = 1; i < WINDOW; i++) begin
      if (m_sw_hist[i] != m_sw_hist[0])   sw_same  = 1'b0;
      if (m_sel_hist[i] != m_sel_hist[0]) sel_same = 1'b0;
    end
    if (sw_same)  m_sw_deb  = m_sw_hist[0];
    if (sel_same) m_sel_deb = m_sel_hist[0];
    m_sw_hist.push_back(SW1);         void'(m_sw_hist.pop_front());
    m_sel_hist.push_back(CLKSEL_REQ); void'(m_sel_hist.pop_front());
    m_as_hist.push_back(AS_CPU_n);    void'(m_as_hist.pop_front());
  endtask

  task automatic check_all(string tag);
    logic [NUM_CLK-1:0] exp_oh;
    exp_oh = ONE << m_cur;
    checks++;
    assert (clksel_onehot === exp_oh) else begin
      errors++; $error("FAIL %s clksel_onehot observed %h expected %h", tag, clksel_onehot, exp_oh);
    end
    checks++;
    assert (use_stock === m_use_stock) else begin
      errors++; $error("FAIL %s use_stock observed %b expected %b", tag, use_stock, m_use_stock);
    end
    checks++;
    assert (busy === (m_phase != P_IDLE)) else begin
      errors++; $error("FAIL %s busy observed %b expected %b", tag, busy, m_phase != P_IDLE);
    end
    checks++;
    assert (cur_sel === m_cur) else begin
      errors++; $error("FAIL %s cur_sel observed %0d expected %0d", tag, cur_sel, m_cur);
    end
`ifdef CLKSW_BUS_TIMEOUT_EN
    checks++;
    assert (timeout_flag === m_tflag) else begin
      errors++; $error("FAIL %s timeout_flag observed %b expected %b", tag, timeout_flag, m_tflag);
    end
`endif
  endtask

  task automatic expect_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(string tag);
    @(posedge C7M);
    model_step();
    @(negedge C7M);
    check_all(tag);
  endtask

  task automatic cycles(int n, string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  function automatic logic observe(int which);
    case (which)
      0: return busy;
      1: return use_stock;
`ifdef CLKSW_BUS_TIMEOUT_EN
      2: return timeout_flag;
`endif
      default: return 1'bx;
    endcase
  endfunction

  task automatic wait_for(string tag, int which, logic val, int limit);
    int n = 0;
    while (observe(which) !== val && n < limit) begin
      cycle(tag);
      n++;
    end
    checks++;
    assert (observe(which) === val) else begin
      errors++;
      $error("FAIL %s wait expired after %0d cycles observed %b required %b", tag, n, observe(which), val);
    end
  endtask

  task automatic pulse_reset(string tag);
    #1 RESET_n = 1'b0;
    model_reset();
    #1 check_all(tag);
    expect_eq({tag, "_onehot"}, 32'(clksel_onehot), 32'h01);
    expect_eq({tag, "_stock"},  32'(use_stock),     32'd1);
    expect_eq({tag, "_busy"},   32'(busy),          32'd0);
    expect_eq({tag, "_cur"},    32'(cur_sel),       32'd0);
    @(posedge C7M);
    @(negedge C7M);
    RESET_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [SEL_W-1:0] r;
    int glitch;
    RESET_n = 1'b0; SW1 = 1'b1; CLKSEL_REQ = '0; AS_CPU_n = 1'b1;
    model_reset();
    repeat (3) @(negedge C7M);
    check_all("reset");
    RESET_n = 1'b1;

    // 1: quiet after reset
    cycles(100, "t1_quiet");
    expect_eq("t1_onehot", 32'(clksel_onehot), 32'h01);
    expect_eq("t1_stock",  32'(use_stock),     32'd1);
    expect_eq("t1_busy",   32'(busy),          32'd0);

    // 2: SW1 to turbo lands 2+7+1 cycles later; short glitches are filtered
    SW1 = 1'b0;
    cycles(9, "t2_latency");
    expect_eq("t2_stock_before", 32'(use_stock), 32'd1);
    cycle("t2_latency");
    expect_eq("t2_stock_after", 32'(use_stock), 32'd0);
    SW1 = 1'b1;
    cycles(5, "t2_glitch5");
    SW1 = 1'b0;
    cycles(15, "t2_glitch5");
    expect_eq("t2_glitch5_stock", 32'(use_stock), 32'd0);
    glitch = $urandom_range(1, 6);
    SW1 = 1'b1;
    cycles(glitch, "t2_glitchr");
    SW1 = 1'b0;
    cycles(15, "t2_glitchr");
    expect_eq("t2_glitchr_stock", 32'(use_stock), 32'd0);

    // 3: select 0 -> 5 with an idle bus
    CLKSEL_REQ = 3'd5;
    wait_for("t3_rise", 1, 1'b1, 30);
    cycles(4, "t3_pre");
    expect_eq("t3_onehot", 32'(clksel_onehot), 32'h20);
    expect_eq("t3_cur",    32'(cur_sel),       32'd5);
    cycles(4, "t3_post");
    expect_eq("t3_busy_drain", 32'(busy), 32'd1);
    cycle("t3_post");
    expect_eq("t3_stock_end", 32'(use_stock), 32'd0);
    expect_eq("t3_busy_end",  32'(busy),      32'd0);

    // 4: bus held busy stalls the sequence in the first drain
    do r = 3'($urandom_range(0, 7)); while (r == 3'd5 || r == 3'd6);
    CLKSEL_REQ = r; AS_CPU_n = 1'b0;
    cycles(12, "t4_debounce");
    cycles(50, "t4_stall");
    expect_eq("t4_busy",   32'(busy),          32'd1);
    expect_eq("t4_onehot", 32'(clksel_onehot), 32'h20);
    expect_eq("t4_stock",  32'(use_stock),     32'd0);
    AS_CPU_n = 1'b1;
    wait_for("t4_done", 0, 1'b0, 40);
    expect_eq("t4_cur",    32'(cur_sel),       32'(r));
    expect_eq("t4_onehot_end", 32'(clksel_onehot), 32'(ONE << r));

    // 5: request changed mid-guard runs as a second sequence; reset in the post guard
    CLKSEL_REQ = 3'd6;
    wait_for("t5_rise", 1, 1'b1, 30);
    cycle("t5_pre");
    CLKSEL_REQ = 3'd3;
    wait_for("t5_first", 0, 1'b0, 40);
    expect_eq("t5_first_cur", 32'(cur_sel), 32'd6);
    wait_for("t5_second_start", 0, 1'b1, 30);
    wait_for("t5_second_end", 0, 1'b0, 40);
    expect_eq("t5_second_cur",    32'(cur_sel),       32'd3);
    expect_eq("t5_second_onehot", 32'(clksel_onehot), 32'h08);
    CLKSEL_REQ = 3'd1;
    wait_for("t5_rise2", 1, 1'b1, 30);
    cycles(5, "t5_to_post");
    expect_eq("t5_post_busy",   32'(busy),          32'd1);
    expect_eq("t5_post_onehot", 32'(clksel_onehot), 32'h02);
    pulse_reset("t5_reset");
    cycles(40, "t5_after_reset");

    // random traffic: switch, select and bus activity
    for (int it = 0; it < 25; it++) begin
      int hold;
      SW1        = 1'($urandom_range(0, 1));
      CLKSEL_REQ = 3'($urandom_range(0, 7));
      hold       = $urandom_range(2, 30);
      for (int c = 0; c < hold; c++) begin
        AS_CPU_n = ($urandom_range(0, 3) != 0);
        cycle("rand");
      end
    end
    AS_CPU_n = 1'b1;
    cycles(60, "rand_settle");

`ifdef CLKSW_BUS_TIMEOUT_EN
    // 6: bus stuck in both drains; each times out after 4096 busy cycles
    SW1 = 1'b0;
    cycles(30, "t6_settle");
    r = m_cur + 3'd1;
    CLKSEL_REQ = r; AS_CPU_n = 1'b0;
    wait_for("t6_timeout", 2, 1'b1, 4300);
    expect_eq("t6_stock", 32'(use_stock), 32'd1);
    expect_eq("t6_busy",  32'(busy),      32'd1);
    wait_for("t6_done", 0, 1'b0, 4400);
    expect_eq("t6_cur",  32'(cur_sel),      32'(r));
    expect_eq("t6_flag", 32'(timeout_flag), 32'd1);
    AS_CPU_n = 1'b1;
    cycles(20, "t6_tail");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
